// File: rtl/fir_tcdm_port_slice_pkg.sv
// Shared constants and helpers for the FIR TCDM per-port timing slice.
package fir_tcdm_port_slice_pkg;

   localparam int unsigned FIR_TCDM_MAX_OUTST_DEFAULT = 4;
   localparam int unsigned FIR_TCDM_RSP_REG_DEFAULT   = 1;

   // Width of a counter that must hold the values 0..max_outst inclusive.
   function automatic int unsigned fir_tcdm_cnt_width(input int unsigned max_outst);
      return $clog2(max_outst + 1);
   endfunction

endpackage

// File: rtl/fir_tcdm_port_slice_if.sv
// Flattened multi-lane TCDM bus bundle (MP lanes, request + response).
//
// Handshake: a request transfers in the cycle where req and gnt are both high.
// Every transferred request (read or write) is answered by exactly one r_valid
// pulse at least one cycle later, in request order, per lane.
interface fir_tcdm_port_slice_if #(
   parameter int unsigned MP = 4,
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32,
   parameter int unsigned BW = DW / 8
);

   logic [MP-1:0]         req;
   logic [MP-1:0]         gnt;
   logic [MP-1:0][AW-1:0] add;
   logic [MP-1:0]         wen;
   logic [MP-1:0][BW-1:0] be;
   logic [MP-1:0][DW-1:0] data;
   logic [MP-1:0][DW-1:0] r_data;
   logic [MP-1:0]         r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );

endinterface

// File: rtl/fir_tcdm_port_slice_lane.sv
// One TCDM lane: 2-entry request buffer, outstanding counter with
// backpressure, sticky unexpected-response flag and response stage.
module fir_tcdm_port_slice_lane
   import fir_tcdm_port_slice_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 32,
   parameter int unsigned BW        = DW / 8,
   parameter int unsigned MAX_OUTST = FIR_TCDM_MAX_OUTST_DEFAULT,
   parameter int unsigned RSP_REG   = FIR_TCDM_RSP_REG_DEFAULT
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          up_req,
   output logic          up_gnt,
   input  logic [AW-1:0] up_add,
   input  logic          up_wen,
   input  logic [BW-1:0] up_be,
   input  logic [DW-1:0] up_data,
   output logic [DW-1:0] up_r_data,
   output logic          up_r_valid,
   output logic          dn_req,
   input  logic          dn_gnt,
   output logic [AW-1:0] dn_add,
   output logic          dn_wen,
   output logic [BW-1:0] dn_be,
   output logic [DW-1:0] dn_data,
   input  logic [DW-1:0] dn_r_data,
   input  logic          dn_r_valid,
   output logic          busy_o,
   output logic          err_o
);

   localparam int unsigned   CW      = fir_tcdm_cnt_width(MAX_OUTST);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

   typedef struct packed {
      logic [AW-1:0] add;
      logic          wen;
      logic [BW-1:0] be;
      logic [DW-1:0] data;
   } req_t;

   req_t [1:0]    mem_q, mem_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [CW-1:0] outst_q, outst_d;
   logic          err_q, err_d;

   logic push, pop, rsp_acc, rsp_unexp;
   req_t head;

   // Grant depends only on registered occupancy, so the upstream gnt never
   // sees the downstream gnt combinationally.
   assign up_gnt    = (cnt_q != 2'd2) & ~clear_i & ~rst_i;
   assign dn_req    = (cnt_q != 2'd0) & (outst_q < MAX_CNT) & ~clear_i & ~rst_i;
   assign push      = up_req & up_gnt;
   assign pop       = dn_req & dn_gnt;
   // A response is legal if something is in flight, or is being issued now.
   assign rsp_acc   = dn_r_valid & ((outst_q != '0) | pop);
   assign rsp_unexp = dn_r_valid & ~rsp_acc;

   assign head    = mem_q[rd_ptr_q];
   assign dn_add  = head.add;
   assign dn_wen  = head.wen;
   assign dn_be   = head.be;
   assign dn_data = head.data;

   assign busy_o = (cnt_q != 2'd0) | (outst_q != '0);
   assign err_o  = err_q;

   // Request FIFO next state; clear empties it and overrides push/pop.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{add: up_add, wen: up_wen, be: up_be, data: up_data};
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Outstanding counter and sticky error; clear keeps in-flight accounting.
   always_comb begin
      outst_d = outst_q;
      if (pop & ~rsp_acc) begin
         outst_d = outst_q + CW'(1);
      end else if (~pop & rsp_acc) begin
         outst_d = outst_q - CW'(1);
      end
      err_d = clear_i ? 1'b0 : (err_q | rsp_unexp);
   end

   // Lane state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         outst_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         outst_q  <= outst_d;
         err_q    <= err_d;
      end
   end

   if (RSP_REG != 0) begin : g_rsp_reg
      logic          r_valid_q, r_valid_d;
      logic [DW-1:0] r_data_q, r_data_d;

      // Response stage: capture only accepted responses, hold data otherwise.
      always_comb begin
         r_valid_d = rsp_acc;
         r_data_d  = rsp_acc ? dn_r_data : r_data_q;
      end

      // Response stage registers.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
         end else begin
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
         end
      end

      assign up_r_valid = r_valid_q;
      assign up_r_data  = r_data_q;
   end else begin : g_rsp_comb
      assign up_r_valid = rsp_acc;
      assign up_r_data  = dn_r_data;
   end

endmodule

// File: rtl/fir_tcdm_port_slice.sv
// Per-port TCDM timing slice between the FIR HWPE and the interconnect:
// MP fully independent lanes, busy is the OR of all lanes.
module fir_tcdm_port_slice
   import fir_tcdm_port_slice_pkg::*;
#(
   parameter int unsigned MP        = 4,
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 32,
   parameter int unsigned BW        = DW / 8,
   parameter int unsigned MAX_OUTST = FIR_TCDM_MAX_OUTST_DEFAULT,
   parameter int unsigned RSP_REG   = FIR_TCDM_RSP_REG_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   fir_tcdm_port_slice_if.slave  up,
   fir_tcdm_port_slice_if.master dn,
   output logic                  busy_o,
   output logic [MP-1:0]         err_o
);

   logic [MP-1:0] busy_lane;

   for (genvar i = 0; i < MP; i++) begin : g_lane
      fir_tcdm_port_slice_lane #(
         .DW        (DW),
         .AW        (AW),
         .BW        (BW),
         .MAX_OUTST (MAX_OUTST),
         .RSP_REG   (RSP_REG)
      ) u_lane (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .clear_i    (clear_i),
         .up_req     (up.req[i]),
         .up_gnt     (up.gnt[i]),
         .up_add     (up.add[i]),
         .up_wen     (up.wen[i]),
         .up_be      (up.be[i]),
         .up_data    (up.data[i]),
         .up_r_data  (up.r_data[i]),
         .up_r_valid (up.r_valid[i]),
         .dn_req     (dn.req[i]),
         .dn_gnt     (dn.gnt[i]),
         .dn_add     (dn.add[i]),
         .dn_wen     (dn.wen[i]),
         .dn_be      (dn.be[i]),
         .dn_data    (dn.data[i]),
         .dn_r_data  (dn.r_data[i]),
         .dn_r_valid (dn.r_valid[i]),
         .busy_o     (busy_lane[i]),
         .err_o      (err_o[i])
      );
   end

   assign busy_o = |busy_lane;

endmodule

// File: tb/tb_fir_tcdm_port_slice.sv
// Self-checking bench for fir_tcdm_port_slice: queue-based per-lane model
// plus directed scenarios and a randomized soak.
`timescale 1ns/1ps
module tb_fir_tcdm_port_slice;

   localparam int MP        = 4;
   localparam int DW        = 32;
   localparam int AW        = 32;
   localparam int BW        = DW / 8;
   localparam int MAX_OUTST = 4;
   localparam int RW        = AW + 1 + BW + DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          busy;
   logic [MP-1:0] err;

   fir_tcdm_port_slice_if #(.MP(MP), .DW(DW), .AW(AW), .BW(BW)) up_if ();
   fir_tcdm_port_slice_if #(.MP(MP), .DW(DW), .AW(AW), .BW(BW)) dn_if ();

   fir_tcdm_port_slice #(
      .MP(MP), .DW(DW), .AW(AW), .BW(BW), .MAX_OUTST(MAX_OUTST), .RSP_REG(1)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .up      (up_if),
      .dn      (dn_if),
      .busy_o  (busy),
      .err_o   (err)
   );

   // clock
   always #5 clk = ~clk;

   // model state: buffered requests, in-flight response data, due cycles
   logic [RW-1:0] m_fifo [MP][$];
   logic [DW-1:0] exp_q  [MP][$];
   int            due_q  [MP][$];
   int            m_outst [MP];
   bit            m_err   [MP];
   bit            m_rv    [MP];
   logic [DW-1:0] m_rd    [MP];

   // stimulus controls
   int up_left [MP];
   int up_pct  [MP];
   int gnt_pct [MP];
   int rsp_budget [MP];
   int dly_min [MP];
   int dly_max [MP];
   bit inj [MP];
   bit force_read [MP];
   int inj_pct;
   int cyc;

   // DUT observations of the last tick
   bit            o_ugnt [MP], o_dreq [MP], o_dhs [MP], o_uhs [MP], o_urv [MP], o_drv [MP];
   logic [RW-1:0] o_pay  [MP];
   logic [MP-1:0] o_err;
   logic          o_busy;

   int tests = 0;
   int fails = 0;

   function automatic logic [DW-1:0] rsp_data(input logic [AW-1:0] a);
      return DW'(a) ^ DW'(32'h5a5a_c3c3);
   endfunction

   function automatic bit model_busy();
      bit b = 1'b0;
      for (int l = 0; l < MP; l++) begin
         if (m_fifo[l].size() > 0 || m_outst[l] > 0 || m_rv[l]) b = 1'b1;
      end
      return b;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < MP; l++) begin
         m_fifo[l].delete();
         exp_q[l].delete();
         due_q[l].delete();
         m_outst[l] = 0;
         m_err[l]   = 1'b0;
         m_rv[l]    = 1'b0;
         m_rd[l]    = '0;
         inj[l]     = 1'b0;
         up_left[l] = 0;
      end
   endtask

   task automatic set_idle();
      for (int l = 0; l < MP; l++) begin
         up_left[l]    = 0;
         up_pct[l]     = 100;
         gnt_pct[l]    = 100;
         rsp_budget[l] = -1;
         dly_min[l]    = 1;
         dly_max[l]    = 3;
         inj[l]        = 1'b0;
         force_read[l] = 1'b0;
      end
      inj_pct = 0;
      clear   = 1'b0;
   endtask

   // One clock cycle: drive, check all outputs against the model, advance model.
   task automatic tick();
      bit            eg [MP], er [MP];
      bit            n_rv [MP];
      logic [DW-1:0] n_rd [MP];
      bit            e_busy, push, pop, acc;
      logic [RW-1:0] w, hd;
      int            d;
      for (int l = 0; l < MP; l++) begin
         eg[l] = !rst && !clear && (m_fifo[l].size() < 2);
         er[l] = !rst && !clear && (m_fifo[l].size() > 0) && (m_outst[l] < MAX_OUTST);
         up_if.req[l]  = (up_left[l] > 0) && (int'($urandom_range(0, 99)) < up_pct[l]);
         up_if.add[l]  = AW'($urandom);
         up_if.wen[l]  = force_read[l] ? 1'b1 : 1'($urandom_range(0, 1));
         up_if.be[l]   = BW'($urandom);
         up_if.data[l] = DW'($urandom);
         dn_if.gnt[l]  = int'($urandom_range(0, 99)) < gnt_pct[l];
         if (!rst && inj_pct > 0 && int'($urandom_range(0, 99)) < inj_pct) inj[l] = 1'b1;
         dn_if.r_valid[l] = 1'b0;
         dn_if.r_data[l]  = DW'($urandom);
         if (!rst && due_q[l].size() > 0 && due_q[l][0] <= cyc && rsp_budget[l] != 0) begin
            dn_if.r_valid[l] = 1'b1;
            dn_if.r_data[l]  = exp_q[l][0];
            if (rsp_budget[l] > 0) rsp_budget[l]--;
         end else if (!rst && inj[l] && exp_q[l].size() == 0 && !(er[l] && dn_if.gnt[l])) begin
            dn_if.r_valid[l] = 1'b1;
            inj[l]           = 1'b0;
         end
      end
      #2;
      e_busy = 1'b0;
      for (int l = 0; l < MP; l++) begin
         o_ugnt[l] = up_if.gnt[l];
         o_dreq[l] = dn_if.req[l];
         o_uhs[l]  = up_if.req[l] & up_if.gnt[l];
         o_dhs[l]  = dn_if.req[l] & dn_if.gnt[l];
         o_urv[l]  = up_if.r_valid[l];
         o_drv[l]  = dn_if.r_valid[l];
         o_pay[l]  = {dn_if.add[l], dn_if.wen[l], dn_if.be[l], dn_if.data[l]};
         if (m_fifo[l].size() > 0 || m_outst[l] > 0) e_busy = 1'b1;
         tests++;
         if (up_if.gnt[l] !== eg[l]) begin
            fails++;
            $display("FAIL up_gnt lane %0d cyc %0d: got %b exp %b", l, cyc, up_if.gnt[l], eg[l]);
         end
         tests++;
         if (dn_if.req[l] !== er[l]) begin
            fails++;
            $display("FAIL dn_req lane %0d cyc %0d: got %b exp %b", l, cyc, dn_if.req[l], er[l]);
         end
         if (er[l]) begin
            tests++;
            if (o_pay[l] !== m_fifo[l][0]) begin
               fails++;
               $display("FAIL dn_payload lane %0d cyc %0d: got %h exp %h", l, cyc, o_pay[l], m_fifo[l][0]);
            end
         end
         tests++;
         if (up_if.r_valid[l] !== m_rv[l]) begin
            fails++;
            $display("FAIL up_r_valid lane %0d cyc %0d: got %b exp %b", l, cyc, up_if.r_valid[l], m_rv[l]);
         end
         if (m_rv[l]) begin
            tests++;
            if (up_if.r_data[l] !== m_rd[l]) begin
               fails++;
               $display("FAIL up_r_data lane %0d cyc %0d: got %h exp %h", l, cyc, up_if.r_data[l], m_rd[l]);
            end
         end
         tests++;
         if (err[l] !== m_err[l]) begin
            fails++;
            $display("FAIL err_o lane %0d cyc %0d: got %b exp %b", l, cyc, err[l], m_err[l]);
         end
      end
      o_err  = err;
      o_busy = busy;
      tests++;
      if (busy !== e_busy) begin
         fails++;
         $display("FAIL busy_o cyc %0d: got %b exp %b", cyc, busy, e_busy);
      end
      for (int l = 0; l < MP; l++) begin
         n_rv[l] = 1'b0;
         n_rd[l] = dn_if.r_data[l];
         if (!rst) begin
            push = up_if.req[l] && eg[l];
            pop  = er[l] && dn_if.gnt[l];
            acc  = dn_if.r_valid[l] && (m_outst[l] > 0 || pop);
            w    = {up_if.add[l], up_if.wen[l], up_if.be[l], up_if.data[l]};
            n_rv[l] = acc;
            if (acc) begin
               m_outst[l]--;
               void'(exp_q[l].pop_front());
               void'(due_q[l].pop_front());
            end
            if (dn_if.r_valid[l] && !acc) m_err[l] = 1'b1;
            if (clear) m_err[l] = 1'b0;
            if (pop) begin
               hd = m_fifo[l].pop_front();
               exp_q[l].push_back(rsp_data(hd[RW-1 -: AW]));
               d = cyc + int'($urandom_range(dly_min[l], dly_max[l]));
               if (due_q[l].size() > 0 && d <= due_q[l][$]) d = due_q[l][$] + 1;
               due_q[l].push_back(d);
               m_outst[l]++;
            end
            if (clear) m_fifo[l].delete();
            else if (push) begin
               m_fifo[l].push_back(w);
               up_left[l]--;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int l = 0; l < MP; l++) begin
         m_rv[l] = rst ? 1'b0 : n_rv[l];
         if (n_rv[l] && !rst) m_rd[l] = n_rd[l];
      end
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      set_idle();
      while (n < 300 && model_busy()) begin
         tick();
         n++;
      end
      tests++;
      if (n >= 300) begin
         fails++;
         $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
      end
      tick();
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      clear = 1'b0;
      set_idle();
      model_reset();
      for (int i = 0; i < 3; i++) tick();
      tests++;
      if (up_if.gnt !== '0 || dn_if.req !== '0 || up_if.r_valid !== '0 || busy !== 1'b0 || err !== '0) begin
         fails++;
         $display("FAIL reset_state: gnt %b req %b rv %b busy %b err %b, required all 0",
                  up_if.gnt, dn_if.req, up_if.r_valid, busy, err);
      end
      rst = 1'b0;
      tick();
      tests++;
      if (!(o_ugnt[0] && o_ugnt[1] && o_ugnt[2] && o_ugnt[3])) begin
         fails++;
         $display("FAIL reset_release_gnt: got %b%b%b%b exp 1111", o_ugnt[3], o_ugnt[2], o_ugnt[1], o_ugnt[0]);
      end
   endtask

   task automatic test_streaming();
      int n_hs = 0, n_low = 0, n_rv = 0, first = -1, last = -1;
      set_idle();
      dly_min[0]    = 2;
      dly_max[0]    = 2;
      up_left[0]    = 16;
      force_read[0] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (o_dhs[0]) begin
            if (first < 0) first = cyc;
            last = cyc;
            n_hs++;
         end
         if (!o_ugnt[0]) n_low++;
         if (o_urv[0]) n_rv++;
      end
      tests++;
      if (n_hs != 16 || (last - first) != 15) begin
         fails++;
         $display("FAIL stream_handshakes: got %0d over span %0d, exp 16 over span 15", n_hs, last - first);
      end
      tests++;
      if (n_low != 0) begin
         fails++;
         $display("FAIL stream_up_gnt: low in %0d cycles, exp 0", n_low);
      end
      tests++;
      if (n_rv != 16) begin
         fails++;
         $display("FAIL stream_responses: got %0d exp 16", n_rv);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int n_uhs = 0, n_dhs = 0;
      bit have = 1'b0;
      logic [RW-1:0] first_pay = '0;
      set_idle();
      gnt_pct[1] = 0;
      up_left[1] = 10;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (o_uhs[1]) n_uhs++;
         if (o_dreq[1]) begin
            if (!have) begin
               first_pay = o_pay[1];
               have      = 1'b1;
            end else begin
               tests++;
               if (o_pay[1] !== first_pay) begin
                  fails++;
                  $display("FAIL bp_payload_stable cyc %0d: got %h exp %h", cyc, o_pay[1], first_pay);
               end
            end
         end
      end
      tests++;
      if (n_uhs != 2 || o_ugnt[1] !== 1'b0) begin
         fails++;
         $display("FAIL bp_fill: %0d handshakes, gnt %b, exp 2 and 0", n_uhs, o_ugnt[1]);
      end
      up_left[1] = 0;
      gnt_pct[1] = 100;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (o_dhs[1]) n_dhs++;
      end
      tests++;
      if (n_dhs != 2) begin
         fails++;
         $display("FAIL bp_drain: got %0d dn handshakes exp 2", n_dhs);
      end
      drain();
   endtask

   task automatic test_outst_limit();
      int n_dhs = 0;
      set_idle();
      rsp_budget[3] = 0;
      up_left[3]    = 6;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (o_dhs[3]) n_dhs++;
      end
      tests++;
      if (n_dhs != MAX_OUTST || o_dreq[3] !== 1'b0 || o_ugnt[3] !== 1'b0 || o_busy !== 1'b1) begin
         fails++;
         $display("FAIL outst_saturate: hs %0d req %b gnt %b busy %b, exp %0d 0 0 1",
                  n_dhs, o_dreq[3], o_ugnt[3], o_busy, MAX_OUTST);
      end
      rsp_budget[3] = 1;
      tick();
      tests++;
      if (o_drv[3] !== 1'b1 || o_dreq[3] !== 1'b0) begin
         fails++;
         $display("FAIL outst_one_rsp: r_valid %b req %b, exp 1 0", o_drv[3], o_dreq[3]);
      end
      tick();
      tests++;
      if (o_dreq[3] !== 1'b1) begin
         fails++;
         $display("FAIL outst_reassert: dn_req %b exp 1", o_dreq[3]);
      end
      drain();
   endtask

   task automatic test_unexpected();
      int n_urv = 0;
      set_idle();
      inj[2] = 1'b1;
      tick();
      if (o_urv[2]) n_urv++;
      tick();
      if (o_urv[2]) n_urv++;
      tests++;
      if (o_err !== 4'b0100) begin
         fails++;
         $display("FAIL unexp_err: got %b exp 0100", o_err);
      end
      tick();
      if (o_urv[2]) n_urv++;
      tests++;
      if (n_urv != 0) begin
         fails++;
         $display("FAIL unexp_forwarded: %0d up_r_valid exp 0", n_urv);
      end
      clear = 1'b1;
      tick();
      tests++;
      if (o_ugnt[0] || o_ugnt[1] || o_ugnt[2] || o_ugnt[3]) begin
         fails++;
         $display("FAIL clear_gnt: got %b%b%b%b exp 0000", o_ugnt[3], o_ugnt[2], o_ugnt[1], o_ugnt[0]);
      end
      clear = 1'b0;
      tick();
      tests++;
      if (o_err !== 4'b0000) begin
         fails++;
         $display("FAIL clear_err: got %b exp 0000", o_err);
      end
   endtask

   task automatic test_simultaneous();
      int n_sim = 0, sim_cyc = -1, rv_cyc = -1, n_rv = 0;
      set_idle();
      dly_min[0]    = 1;
      dly_max[0]    = 1;
      up_left[0]    = 2;
      force_read[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (o_dhs[0] && o_drv[0]) begin
            n_sim++;
            sim_cyc = cyc;
         end
         if (o_urv[0]) begin
            n_rv++;
            if (rv_cyc < 0) rv_cyc = cyc;
         end
      end
      tests++;
      if (n_sim != 1 || o_err[0] !== 1'b0) begin
         fails++;
         $display("FAIL simul_overlap: %0d overlaps err %b, exp 1 and 0", n_sim, o_err[0]);
      end
      tests++;
      if (n_rv != 2 || rv_cyc != sim_cyc + 1) begin
         fails++;
         $display("FAIL simul_rsp_timing: %0d responses first at %0d, exp 2 at %0d", n_rv, rv_cyc, sim_cyc + 1);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      set_idle();
      rsp_budget[1] = 0;
      up_left[1]    = 3;
      for (int i = 0; i < 5; i++) tick();
      gnt_pct[1] = 0;
      up_left[1] = 2;
      for (int i = 0; i < 4; i++) tick();
      tests++;
      if (m_outst[1] != 3 || m_fifo[1].size() != 2 || o_busy !== 1'b1) begin
         fails++;
         $display("FAIL midrst_setup: outst %0d fifo %0d busy %b, exp 3 2 1", m_outst[1], m_fifo[1].size(), o_busy);
      end
      #3;
      rst = 1'b1;
      #1;
      tests++;
      if (up_if.gnt !== '0 || dn_if.req !== '0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL midrst_immediate: gnt %b req %b busy %b, exp 0", up_if.gnt, dn_if.req, busy);
      end
      model_reset();
      set_idle();
      tick();
      tick();
      rst = 1'b0;
      tick();
      inj[1] = 1'b1;
      tick();
      tick();
      tests++;
      if (o_err !== 4'b0010) begin
         fails++;
         $display("FAIL midrst_late_rsp_err: got %b exp 0010", o_err);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
   endtask

   task automatic test_random();
      set_idle();
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) begin
            for (int l = 0; l < MP; l++) begin
               up_left[l] = int'($urandom_range(0, 40));
               up_pct[l]  = int'($urandom_range(30, 100));
               gnt_pct[l] = int'($urandom_range(20, 100));
               dly_min[l] = 1;
               dly_max[l] = int'($urandom_range(1, 5));
            end
            inj_pct = int'($urandom_range(0, 3));
         end
         clear = ($urandom_range(0, 199) == 0);
         tick();
      end
      drain();
      tests++;
      if (o_busy !== 1'b0) begin
         fails++;
         $display("FAIL random_final_busy: got %b exp 0", o_busy);
      end
   endtask

   initial begin
      rst = 1'b1;
      clear = 1'b0;
      cyc = 0;
      up_if.req = '0;
      dn_if.gnt = '0;
      dn_if.r_valid = '0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_outst_limit();
      test_unexpected();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
